bus_access_controller: RTL and testbench
========================================

BUS_ACCESS_CONTROLLER -- requirements
Module: bus_access_controller

Interface
REQ-001 Parameter TIMEOUT, default 255, 8-bit bus-timeout preload value.
REQ-002 Ports SHALL be exactly as listed; one clock; reset is asynchronous and active-low.
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- req0 / req1  in  1 each  access request; 0 = instruction fetch, 1 = data.
- we0 / we1  in  1 each  write enable per requester.
- addr0 / addr1  in  32 each  byte address per requester.
- wdata0 / wdata1  in  32 each  write data per requester.
- ack0 / ack1  out  1 each  one-cycle completion pulse.
- err0 / err1  out  1 each  one-cycle timeout-error pulse.
- rdata  out  32  read data, valid while ackN=1.
- bus_stb  out  1  bus strobe.
- bus_we  out  1  bus write enable.
- bus_addr  out  32  bus address.
- bus_wdata  out  32  bus write data.
- bus_rdata  in  32  bus read data.
- bus_ack  in  1  bus acknowledge.
- err_addr  out  32  address of the most recent timed-out access.

Function
REQ-003 States SHALL be IDLE, ACCESS and RESP; all outputs SHALL be registered.
REQ-004 IDLE: when any reqN=1 at a clock edge, the block SHALL grant, latch weN/addrN/wdataN of the granted requester, load an 8-bit counter with TIMEOUT, and enter ACCESS.
REQ-005 Arbitration SHALL be round-robin: a lone requester wins; on simultaneous requests the requester not granted last wins; the last-grant pointer SHALL update on every grant.
REQ-006 ACCESS: bus_stb=1; bus_we, bus_addr and bus_wdata SHALL hold the latched values, unchanged for the whole access.
REQ-007 ACCESS with bus_ack=1 at an edge: the block SHALL latch bus_rdata into rdata, pulse ackN of the owner in the next cycle (RESP), and drop bus_stb.
REQ-008 ACCESS with bus_ack=0 and counter≠0: counter SHALL decrement by 1.
REQ-009 ACCESS with bus_ack=0 and counter=0: the block SHALL pulse errN of the owner in the next cycle (RESP), drop bus_stb, and latch the access address into err_addr. With TIMEOUT=T the strobe therefore lasts T+1 cycles.
REQ-010 If bus_ack=1 and counter=0 in the same cycle, ack SHALL win: ackN pulses, errN stays 0, err_addr is unchanged.
REQ-011 RESP SHALL last exactly one cycle and grant nothing; the next state SHALL be IDLE.
REQ-012 After RESP, requesters SHALL have dropped reqN; a reqN still high in IDLE is a new request.
REQ-013 Latency: reqN sampled at edge k → bus_stb high in cycle k+1; bus_ack sampled at edge m → ackN high in cycle m+1; earliest next grant at the edge ending the first IDLE cycle.
REQ-014 A reqN dropped during ACCESS SHALL NOT abort the access; the ackN/errN response SHALL still be issued.
REQ-015 rdata SHALL hold its value until the next read completion; writes SHALL NOT modify rdata.
REQ-016 ackN/errN SHALL never be high simultaneously, nor for the non-owner.

Reset
REQ-017 On reset_n=0, asynchronously: state=IDLE; bus_stb, bus_we, ack0/1 and err0/1 = 0; bus_addr, bus_wdata, rdata and err_addr = 0; counter=TIMEOUT; last-grant pointer = 1, so requester 0 wins the first tie.
REQ-018 Reset asserted mid-ACCESS SHALL drop bus_stb immediately with no ack or err pulse; operation resumes from IDLE after reset_n=1.

Verification
REQ-019 Single read: req0, addr0=0x100, bus_ack after 3 strobe cycles with bus_rdata=0xDEADBEEF -> ack0 one cycle, rdata=0xDEADBEEF, bus_stb low in the RESP cycle.
REQ-020 Tie: req0=req1=1 held repeatedly after reset -> grants alternate 0,1,0,1; bus_addr matches the granted addrN.
REQ-021 Timeout: TIMEOUT=4, req1 write to 0x2000, no bus_ack -> bus_stb high exactly 5 cycles, err1 one cycle, err_addr=0x2000, ack1=0.
REQ-022 Simultaneous: bus_ack arrives in the cycle where counter=0 -> ack pulse, no err, err_addr unchanged.
REQ-023 Reset mid-access: reset_n pulsed low at strobe cycle 2 -> bus_stb=0 asynchronously, no ack/err, next request granted normally.
REQ-024 Aborted request: req0 dropped in ACCESS -> access completes and ack0 still pulses on bus_ack.

Source files
------------

// File: rtl/bus_access_controller.sv
// Two-requester bus access controller: round-robin grant, one bus access at a
// time, with an ack or timeout-error response returned to the owner.
module bus_access_controller #(
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic        ack0,
    output logic        ack1,
    output logic        err0,
    output logic        err1,
    output logic [31:0] rdata,
    output logic        bus_stb,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic [31:0] err_addr
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic        last_q, last_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        stb_q, stb_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] err_addr_q, err_addr_d;
    logic [1:0]  ack_q, ack_d;
    logic [1:0]  err_q, err_d;
    logic        grant;

    // On a tie the requester that did not win last time gets the bus.
    assign grant = (req0 && req1) ? ~last_q : req1;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        stb_d      = stb_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        err_addr_d = err_addr_q;
        ack_d      = 2'b00;
        err_d      = 2'b00;

        unique case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    owner_d = grant;
                    last_d  = grant;
                    we_d    = grant ? we1 : we0;
                    addr_d  = grant ? addr1 : addr0;
                    wdata_d = grant ? wdata1 : wdata0;
                    cnt_d   = TIMEOUT;
                    stb_d   = 1'b1;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (bus_ack) begin
                    // rdata only tracks read completions; writes leave it alone.
                    if (!we_q) begin
                        rdata_d = bus_rdata;
                    end
                    ack_d[owner_q] = 1'b1;
                    stb_d          = 1'b0;
                    state_d        = RESP;
                end else if (cnt_q == 8'd0) begin
                    err_d[owner_q] = 1'b1;
                    err_addr_d     = addr_q;
                    stb_d          = 1'b0;
                    state_d        = RESP;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                stb_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            last_q     <= 1'b1;
            cnt_q      <= TIMEOUT;
            stb_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            rdata_q    <= 32'd0;
            err_addr_q <= 32'd0;
            ack_q      <= 2'b00;
            err_q      <= 2'b00;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            stb_q      <= stb_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            err_addr_q <= err_addr_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
        end
    end

    assign bus_stb   = stb_q;
    assign bus_we    = we_q;
    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;
    assign rdata     = rdata_q;
    assign err_addr  = err_addr_q;
    assign ack0      = ack_q[0];
    assign ack1      = ack_q[1];
    assign err0      = err_q[0];
    assign err1      = err_q[1];

endmodule

// File: tb/tb_bus_access_controller.sv
// Randomized bench for bus_access_controller against a transaction-level model
// of grant order, response kind, rdata and err_addr.
module tb_bus_access_controller;

    localparam int T = 4;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
    logic        ack0, ack1, err0, err1;
    logic [31:0] rdata;
    logic        bus_stb, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [31:0] bus_rdata = '0;
    logic        bus_ack = 1'b0;
    logic [31:0] err_addr;

    int n_vec = 0;
    int n_err = 0;

    // Model state.
    bit          last_m;
    logic [31:0] rdata_m;
    logic [31:0] err_addr_m;

    bus_access_controller #(.TIMEOUT(8'(T))) dut (
        .clock(clock), .reset_n(reset_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
        .rdata(rdata), .bus_stb(bus_stb), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_ack(bus_ack), .err_addr(err_addr)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] resp_bits();
        return {28'd0, err1, err0, ack1, ack0};
    endfunction

    // ackcyc: strobe cycle (1..T+1) in which bus_ack is raised; 0 means never.
    task automatic do_txn(input bit r0, input bit r1, input bit w0, input bit w1,
                          input logic [31:0] a0, input logic [31:0] a1,
                          input logic [31:0] d0, input logic [31:0] d1,
                          input int ackcyc, input logic [31:0] rd);
        bit          win;
        bit          exp_we;
        logic [31:0] exp_addr, exp_wdata;
        logic [31:0] exp_resp;
        win       = (r0 && r1) ? !last_m : r1;
        last_m    = win;
        exp_we    = win ? w1 : w0;
        exp_addr  = win ? a1 : a0;
        exp_wdata = win ? d1 : d0;
        if (ackcyc >= 1 && ackcyc <= T + 1) begin
            exp_resp = win ? 32'h2 : 32'h1;
            if (!exp_we) rdata_m = rd;
        end else begin
            exp_resp   = win ? 32'h8 : 32'h4;
            err_addr_m = exp_addr;
        end

        @(negedge clock);
        check("idle_stb", {31'd0, bus_stb}, 32'd0);
        req0 = r0; req1 = r1; we0 = w0; we1 = w1;
        addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
        @(posedge clock);
        @(negedge clock);
        req0 = 1'b0; req1 = 1'b0;
        addr0 = $urandom; addr1 = $urandom; wdata0 = $urandom; wdata1 = $urandom;
        for (int cyc = 1; cyc <= T + 1; cyc++) begin
            check("stb", {31'd0, bus_stb}, 32'd1);
            check("bus_addr", bus_addr, exp_addr);
            check("bus_we", {31'd0, bus_we}, {31'd0, exp_we});
            check("bus_wdata", bus_wdata, exp_wdata);
            check("resp_busy", resp_bits(), 32'd0);
            bus_ack   = (cyc == ackcyc);
            bus_rdata = (cyc == ackcyc) ? rd : $urandom;
            @(posedge clock);
            if (cyc == ackcyc || cyc == T + 1) break;
            @(negedge clock);
        end
        @(negedge clock);
        bus_ack = 1'b0;
        check("resp_stb", {31'd0, bus_stb}, 32'd0);
        check("resp", resp_bits(), exp_resp);
        check("rdata", rdata, rdata_m);
        check("err_addr", err_addr, err_addr_m);
        $display("txn req=%b%b win=%0d we=%0d addr=%08h ackcyc=%0d resp=%h rdata=%08h err_addr=%08h",
                 r1, r0, win, exp_we, exp_addr, ackcyc, resp_bits(), rdata, err_addr);
    endtask

    task automatic model_reset();
        last_m     = 1'b1;
        rdata_m    = '0;
        err_addr_m = '0;
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        check("rst_stb", {31'd0, bus_stb}, 32'd0);
        check("rst_resp", resp_bits(), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_err_addr", err_addr, 32'd0);
        check("rst_bus_addr", bus_addr, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        // Single read with ack in the third strobe cycle.
        do_txn(1, 0, 0, 0, 32'h100, 32'h0, 32'h0, 32'h0, 3, 32'hDEADBEEF);
        // Ties after a grant to 0: expect 1,0,1,0.
        for (int i = 0; i < 4; i++)
            do_txn(1, 1, 0, 1, 32'hA000 + i, 32'hB000 + i, $urandom, $urandom, 1, $urandom);
        // Write to 0x2000 by requester 1 with no ack: timeout after T+1 strobes.
        do_txn(0, 1, 0, 1, 32'h0, 32'h2000, 32'h0, 32'h55AA, 0, 32'h0);
        // Ack exactly in the counter==0 cycle: ack wins, err_addr stays.
        do_txn(1, 0, 0, 0, 32'h3000, 32'h0, 32'h0, 32'h0, T + 1, 32'h12345678);
        // A write completion must not disturb rdata.
        do_txn(1, 0, 1, 0, 32'h4000, 32'h0, 32'hCAFE, 32'h0, 2, 32'hFFFF0000);

        for (int i = 0; i < 200; i++) begin
            bit r0, r1;
            int ac;
            r0 = $urandom_range(0, 1);
            r1 = $urandom_range(0, 1);
            if (!r0 && !r1) r0 = 1'b1;
            ac = $urandom_range(0, T + 1);
            do_txn(r0, r1, $urandom_range(0, 1), $urandom_range(0, 1),
                   $urandom, $urandom, $urandom, $urandom, ac, $urandom);
        end

        // Reset asserted in strobe cycle 2.
        @(negedge clock);
        req0 = 1'b1; addr0 = 32'h300; we0 = 1'b0;
        @(posedge clock);
        @(negedge clock);
        req0 = 1'b0;
        check("pre_rst_stb", {31'd0, bus_stb}, 32'd1);
        @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_stb", {31'd0, bus_stb}, 32'd0);
        check("async_rst_resp", resp_bits(), 32'd0);
        model_reset();
        @(negedge clock);
        check("post_rst_rdata", rdata, 32'd0);
        check("post_rst_err_addr", err_addr, 32'd0);
        reset_n = 1'b1;
        $display("txn mid-access reset applied");
        do_txn(1, 1, 0, 0, 32'h500, 32'h600, 32'h0, 32'h0, 2, 32'hABCD0123);
        do_txn(1, 1, 0, 0, 32'h700, 32'h800, 32'h0, 32'h0, 0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
